// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state type and small operation-decode helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE_Z
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Shared iterative multiply/divide engine: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with final sign fix-up.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             r_state;
    state_e             w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mag_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_done;
    logic               r_div_zero;

    logic               w_signed_op;
    logic               w_div_op;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_tmp;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed_op = op_is_signed(op);
    assign w_div_op    = op_is_div(op);
    assign w_mag_a     = (w_signed_op && a[WIDTH-1]) ? -a : a;
    assign w_mag_b     = (w_signed_op && b[WIDTH-1]) ? -b : b;

    // Multiply: accumulator holds {partial product, remaining multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mag_b};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1:1]};

    // Divide: accumulator holds {partial remainder, dividend/quotient bits}.
    assign w_div_tmp  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff = w_div_tmp - {1'b0, r_mag_b};
    assign w_div_ge   = ~w_div_diff[WIDTH];
    assign w_div_next = {w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_tmp[WIDTH-1:0],
                         r_acc[WIDTH-2:0], w_div_ge};

    assign w_step = r_is_div ? w_div_next : w_mul_next;

    // FIX performs the last iteration and the sign correction in one cycle.
    assign w_prod = (r_sign_a ^ r_sign_b) ? -w_step : w_step;
    assign w_quo  = (r_sign_a ^ r_sign_b) ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
    assign w_rem  = r_sign_a ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns the next state; no latch.
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_div_op && (b == '0)) w_state_next = S_DONE_Z;
                    else if (w_div_op)         w_state_next = S_DIV;
                    else                       w_state_next = S_MUL;
                end
            end
            S_MUL, S_DIV: if (r_cnt == CW'(2)) w_state_next = S_FIX;
            S_FIX, S_DONE_Z: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mag_b    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_div_zero <= 1'b0;
                        r_is_div   <= w_div_op;
                        r_sign_a   <= w_signed_op & a[WIDTH-1];
                        r_sign_b   <= w_signed_op & b[WIDTH-1];
                        r_mag_b    <= w_mag_b;
                        r_acc      <= {{WIDTH{1'b0}}, w_mag_a};
                        r_cnt      <= CW'(WIDTH);
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_cnt  <= r_cnt - CW'(1);
                    r_hi   <= r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
                    r_lo   <= r_is_div ? w_quo : w_prod[WIDTH-1:0];
                    r_done <= 1'b1;
                end
                S_DONE_Z: begin
                    r_div_zero <= 1'b1;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, randomized operations
// against a plain-arithmetic reference model, handshake and reset scenarios.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dz = 1'b0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    // Reference: 64-bit arithmetic; SV / and % truncate toward zero, so the
    // remainder already carries the dividend's sign.
    function automatic void model(input logic [1:0] m_op, input logic [W-1:0] m_a,
                                  input logic [W-1:0] m_b, inout logic [W-1:0] m_hi,
                                  inout logic [W-1:0] m_lo, output logic m_dz);
        longint       sa = longint'($signed(m_a));
        longint       sb = longint'($signed(m_b));
        logic [63:0]  p;
        m_dz = 1'b0;
        case (m_op)
            OP_MULT:  begin p = sa * sb; {m_hi, m_lo} = p; end
            OP_MULTU: begin p = {32'b0, m_a} * {32'b0, m_b}; {m_hi, m_lo} = p; end
            OP_DIV: begin
                if (m_b == '0) m_dz = 1'b1;
                else begin m_lo = W'(sa / sb); m_hi = W'(sa % sb); end
            end
            default: begin
                if (m_b == '0) m_dz = 1'b1;
                else begin m_lo = m_a / m_b; m_hi = m_a % m_b; end
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] m_op, input logic [W-1:0] m_b);
        return ((m_op[1] == 1'b1) && (m_b == '0)) ? 2 : W + 1;
    endfunction

    // Caller must be away from a rising edge. Returns #1 after the edge that
    // made done visible (the done cycle), or after the cycle budget expires.
    task automatic run_op(input logic [1:0] t_op, input logic [W-1:0] t_a,
                          input logic [W-1:0] t_b, input int glitch_at,
                          output int n_edges, output bit busy_ok);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        n_edges = 1;
        busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && n_edges < 100) begin
            start = (n_edges == glitch_at);
            if (start) begin a = $urandom; b = $urandom; op = 2'($urandom); end
            @(posedge clk); #1;
            n_edges++;
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        #12;
        checks++;
        if ({busy, done, div_zero, hi, lo} !== '0) begin
            $display("FAIL reset_state got busy=%b done=%b dz=%b hi=%h lo=%h exp all 0",
                     busy, done, div_zero, hi, lo);
            errors++;
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_multu_latency();
        int n; bit ok; logic dz;
        @(negedge clk);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, n, ok);
        model(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, exp_hi, exp_lo, dz);
        checks += 5;
        if (n !== 33) begin $display("FAIL multu_latency got %0d exp 33", n); errors++; end
        if (!ok) begin $display("FAIL multu_busy got low exp high"); errors++; end
        if (busy !== 1'b0) begin $display("FAIL busy_in_done got %b exp 0", busy); errors++; end
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            $display("FAIL multu_max got %h_%h exp fffffffe_00000001", hi, lo); errors++;
        end
        @(posedge clk); #1;
        if (done !== 1'b0) begin $display("FAIL done_width got %b exp 0", done); errors++; end
    endtask

    task automatic test_directed();
        logic [1:0]   t_op [5] = '{OP_MULT, OP_MULT, OP_DIV, OP_DIVU, OP_DIV};
        logic [W-1:0] t_a  [5] = '{-32'sd3, 32'h8000_0000, -32'sd7, 32'd7, 32'h8000_0000};
        logic [W-1:0] t_b  [5] = '{32'd7, 32'h8000_0000, 32'd2, 32'd2, 32'hFFFF_FFFF};
        logic [W-1:0] k_hi [5] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 32'd1, 32'd0};
        logic [W-1:0] k_lo [5] = '{32'hFFFF_FFEB, 32'd0, 32'hFFFF_FFFD, 32'd3, 32'h8000_0000};
        int n; bit ok; logic dz;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            run_op(t_op[i], t_a[i], t_b[i], 0, n, ok);
            model(t_op[i], t_a[i], t_b[i], exp_hi, exp_lo, dz);
            checks += 3;
            if ({hi, lo} !== {k_hi[i], k_lo[i]} || {hi, lo} !== {exp_hi, exp_lo}) begin
                $display("FAIL directed_%0d got %h_%h exp %h_%h", i, hi, lo, k_hi[i], k_lo[i]);
                errors++;
            end
            if (div_zero !== 1'b0) begin $display("FAIL directed_dz_%0d got %b exp 0", i, div_zero); errors++; end
            if (n !== W + 1 || !ok) begin
                $display("FAIL directed_lat_%0d got %0d busy_ok=%b exp %0d", i, n, ok, W + 1); errors++;
            end
        end
    endtask

    task automatic test_div_zero();
        int n; bit ok; logic dz;
        @(negedge clk);
        run_op(OP_MULTU, 32'd2, 32'd3, 0, n, ok);
        model(OP_MULTU, 32'd2, 32'd3, exp_hi, exp_lo, dz);
        @(negedge clk);
        run_op(OP_DIVU, 32'd5, 32'd0, 0, n, ok);
        model(OP_DIVU, 32'd5, 32'd0, exp_hi, exp_lo, dz);
        checks += 3;
        if (n !== 2) begin $display("FAIL dz_latency got %0d exp 2", n); errors++; end
        if (div_zero !== 1'b1 || dz !== 1'b1) begin $display("FAIL dz_flag got %b exp 1", div_zero); errors++; end
        if ({hi, lo} !== {32'd0, 32'd6}) begin $display("FAIL dz_hold got %h_%h exp 0_6", hi, lo); errors++; end
        repeat (3) @(negedge clk);
        checks++;
        if (div_zero !== 1'b1) begin $display("FAIL dz_held got %b exp 1", div_zero); errors++; end
        start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
        @(posedge clk); #1; start = 1'b0;
        checks++;
        if (div_zero !== 1'b0) begin $display("FAIL dz_clear got %b exp 0", div_zero); errors++; end
        n = 0;
        while (done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        model(OP_MULTU, 32'd9, 32'd9, exp_hi, exp_lo, dz);
        checks++;
        if (done !== 1'b1 || lo !== exp_lo) begin
            $display("FAIL dz_next_op got done=%b lo=%h exp done=1 lo=%h", done, lo, exp_lo); errors++;
        end
    endtask

    task automatic test_back_to_back();
        int n; bit ok; logic dz;
        @(negedge clk);
        run_op(OP_DIV, 32'd100, -32'sd7, 0, n, ok);
        model(OP_DIV, 32'd100, -32'sd7, exp_hi, exp_lo, dz);
        checks++;
        if ({hi, lo} !== {exp_hi, exp_lo}) begin
            $display("FAIL b2b_first got %h_%h exp %h_%h", hi, lo, exp_hi, exp_lo); errors++;
        end
        run_op(OP_MULT, -32'sd12345, 32'd6789, 0, n, ok);
        model(OP_MULT, -32'sd12345, 32'd6789, exp_hi, exp_lo, dz);
        checks += 2;
        if ({hi, lo} !== {exp_hi, exp_lo}) begin
            $display("FAIL b2b_second got %h_%h exp %h_%h", hi, lo, exp_hi, exp_lo); errors++;
        end
        if (n !== W + 1) begin $display("FAIL b2b_latency got %0d exp %0d", n, W + 1); errors++; end
    endtask

    task automatic test_ignore_start();
        int n; bit ok; logic dz;
        @(negedge clk);
        run_op(OP_DIVU, 32'hDEAD_BEEF, 32'd1000, 5, n, ok);
        model(OP_DIVU, 32'hDEAD_BEEF, 32'd1000, exp_hi, exp_lo, dz);
        checks += 2;
        if ({hi, lo} !== {exp_hi, exp_lo}) begin
            $display("FAIL ignore_start got %h_%h exp %h_%h", hi, lo, exp_hi, exp_lo); errors++;
        end
        if (n !== W + 1 || !ok) begin $display("FAIL ignore_lat got %0d exp %0d", n, W + 1); errors++; end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin $display("FAIL ignore_restart got busy=%b exp 0", busy); errors++; end
    endtask

    task automatic test_reset_mid();
        int n; bit ok; bit saw_done = 1'b0; logic dz;
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        #1; reset = 1'b1; #1;
        checks++;
        if ({busy, done, hi, lo} !== '0) begin
            $display("FAIL reset_mid got busy=%b hi=%h lo=%h exp 0", busy, hi, lo); errors++;
        end
        exp_hi = '0; exp_lo = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); saw_done |= done;
            if (i == 2) reset = 1'b0;
        end
        checks++;
        if (saw_done) begin $display("FAIL reset_no_done got 1 exp 0"); errors++; end
        run_op(OP_MULTU, 32'd4, 32'd5, 0, n, ok);
        model(OP_MULTU, 32'd4, 32'd5, exp_hi, exp_lo, dz);
        checks++;
        if ({hi, lo} !== {32'd0, 32'd20} || lo !== exp_lo) begin
            $display("FAIL post_reset got %h_%h exp 0_14", hi, lo); errors++;
        end
    endtask

    task automatic test_random();
        int n; bit ok; logic dz;
        logic [1:0] r_op; logic [W-1:0] r_a, r_b;
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom);
            r_a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            case ($urandom_range(0, 5))
                0:       r_b = '0;
                1:       r_b = '1;
                2:       r_b = W'($urandom_range(1, 9));
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            run_op(r_op, r_a, r_b, 0, n, ok);
            model(r_op, r_a, r_b, exp_hi, exp_lo, dz);
            checks++;
            if ({hi, lo, div_zero} !== {exp_hi, exp_lo, dz} || n !== exp_latency(r_op, r_b) || !ok) begin
                $display("FAIL random_%0d op=%0d a=%h b=%h got %h_%h dz=%b lat=%0d exp %h_%h dz=%b lat=%0d",
                         i, r_op, r_a, r_b, hi, lo, div_zero, n, exp_hi, exp_lo, dz,
                         exp_latency(r_op, r_b));
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu_latency();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
